// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: immediate formats, control FSM states, opcodes and
// datapath select encodings used by the multicycle controller and its decoder.
package riscv_pkg;

    typedef enum logic [2:0] {
        INSTR_TYPE_R,
        INSTR_TYPE_I,
        INSTR_TYPE_S,
        INSTR_TYPE_B,
        INSTR_TYPE_U,
        INSTR_TYPE_J
    } instr_type_enum;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMREAD,
        ST_MEMWB,
        ST_MEMWRITE,
        ST_EXECUTER,
        ST_EXECUTEI,
        ST_ALUWB,
        ST_BEQ,
        ST_JAL,
        ST_LUI,
        ST_ILLEGAL
    } ctrl_state_enum;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/instr_type_decoder.sv
// Combinational opcode -> immediate format decode; kept separate so a future
// pipelined decoder can reuse it unchanged.
module instr_type_decoder
    import riscv_pkg::*;
(
    input  logic [6:0]     i_opcode,
    output instr_type_enum o_instr_type
);

    always_comb begin
        o_instr_type = INSTR_TYPE_R;
        case (i_opcode)
            OP_R:            o_instr_type = INSTR_TYPE_R;
            OP_IMM, OP_LOAD: o_instr_type = INSTR_TYPE_I;
            OP_STORE:        o_instr_type = INSTR_TYPE_S;
            OP_BRANCH:       o_instr_type = INSTR_TYPE_B;
            OP_LUI:          o_instr_type = INSTR_TYPE_U;
            OP_JAL:          o_instr_type = INSTR_TYPE_J;
            default:         o_instr_type = INSTR_TYPE_R;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute
// over the shared ALU and single memory port, and counts retired instructions.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [6:0]     opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_write,
    output logic           adr_src,
    output logic           ir_write,
    output logic           pc_write,
    output logic           reg_write,
    output logic [1:0]     alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     result_src,
    output instr_type_enum instr_type_enum_inst,
    output logic           illegal_instr,
    output logic [31:0]    instret,
    output ctrl_state_enum dbg_state
);

    ctrl_state_enum r_state;
    ctrl_state_enum w_next_state;
    logic [31:0]    r_instret;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_reg_write;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_result_src;
    logic       w_retire;

    // Memory handshake: in FETCH/MEMREAD/MEMWRITE the request is held until
    // mem_ready is seen high in the same cycle; mem_ready elsewhere is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = ST_MEMADR;
                    OP_R:              w_next_state = ST_EXECUTER;
                    OP_IMM:            w_next_state = ST_EXECUTEI;
                    OP_BRANCH:         w_next_state = ST_BEQ;
                    OP_JAL:            w_next_state = ST_JAL;
                    OP_LUI:            w_next_state = ST_LUI;
                    default:           w_next_state = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR:   w_next_state = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD: begin
                if (mem_ready) w_next_state = ST_MEMWB;
            end
            ST_MEMWB:    w_next_state = ST_FETCH;
            ST_MEMWRITE: begin
                if (mem_ready) w_next_state = ST_FETCH;
            end
            ST_EXECUTER: w_next_state = ST_ALUWB;
            ST_EXECUTEI: w_next_state = ST_ALUWB;
            ST_ALUWB:    w_next_state = ST_FETCH;
            ST_BEQ:      w_next_state = ST_FETCH;
            ST_JAL:      w_next_state = ST_ALUWB;
            ST_LUI:      w_next_state = ST_ALUWB;
            ST_ILLEGAL:  w_next_state = ST_ILLEGAL;
            default:     w_next_state = ST_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        w_result_src = RES_ALUOUT;
        case (r_state)
            ST_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_a  = SRCA_PC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = mem_ready;
                w_pc_update  = mem_ready;
            end
            ST_DECODE: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
            end
            ST_MEMADR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            ST_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
            end
            ST_EXECUTER: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_RS2;
                w_alu_op    = ALUOP_FUNCT;
            end
            ST_EXECUTEI: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
                w_alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
            end
            ST_BEQ: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_RS2;
                w_alu_op     = ALUOP_SUB;
                w_result_src = RES_ALUOUT;
                w_branch     = 1'b1;
            end
            ST_JAL: begin
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALUOUT;
                w_pc_update  = 1'b1;
            end
            ST_LUI: begin
                w_alu_src_a = SRCA_ZERO;
                w_alu_src_b = SRCB_IMM;
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    assign w_retire = (r_state == ST_MEMWB) || (r_state == ST_ALUWB) || (r_state == ST_BEQ)
                   || ((r_state == ST_MEMWRITE) && mem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    instr_type_decoder u_instr_type_decoder (
        .i_opcode     (opcode),
        .o_instr_type (instr_type_enum_inst)
    );

    // Reset is asynchronous, so the state-changing enables are masked
    // combinationally rather than waiting for the state register to settle.
    assign mem_req       = w_mem_req & ~reset;
    assign mem_write     = w_mem_write & ~reset;
    assign ir_write      = w_ir_write & ~reset;
    assign pc_write      = (w_pc_update | (w_branch & zero)) & ~reset;
    assign reg_write     = w_reg_write & ~reset;
    assign adr_src       = w_adr_src;
    assign alu_src_a     = w_alu_src_a;
    assign alu_src_b     = w_alu_src_b;
    assign alu_op        = w_alu_op;
    assign result_src    = w_result_src;
    assign illegal_instr = (r_state == ST_ILLEGAL);
    assign instret       = r_instret;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed reset/illegal/wrap scenarios plus random
// instruction streams checked against per-instruction cost and pulse-count rules.
module tb_multicycle_ctrl;
    import riscv_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [6:0]     opcode = 7'd0;
    logic           zero = 1'b0;
    logic           mem_ready = 1'b0;
    logic           mem_req;
    logic           mem_write;
    logic           adr_src;
    logic           ir_write;
    logic           pc_write;
    logic           reg_write;
    logic [1:0]     alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     result_src;
    instr_type_enum instr_type_enum_inst;
    logic           illegal_instr;
    logic [31:0]    instret;
    ctrl_state_enum dbg_state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_instret = 32'd0;

    multicycle_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .opcode               (opcode),
        .zero                 (zero),
        .mem_ready            (mem_ready),
        .mem_req              (mem_req),
        .mem_write            (mem_write),
        .adr_src              (adr_src),
        .ir_write             (ir_write),
        .pc_write             (pc_write),
        .reg_write            (reg_write),
        .alu_src_a            (alu_src_a),
        .alu_src_b            (alu_src_b),
        .alu_op               (alu_op),
        .result_src           (result_src),
        .instr_type_enum_inst (instr_type_enum_inst),
        .illegal_instr        (illegal_instr),
        .instret              (instret),
        .dbg_state            (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference rules: cycle cost and side effects per instruction class.
    function automatic bit is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic int base_cycles(input logic [6:0] op);
        if (op == OP_LOAD)   return 5;
        if (op == OP_BRANCH) return 3;
        return 4;
    endfunction

    function automatic int exp_reg_writes(input logic [6:0] op);
        return (op == OP_STORE || op == OP_BRANCH) ? 0 : 1;
    endfunction

    function automatic instr_type_enum exp_type(input logic [6:0] op);
        if (op == OP_IMM || op == OP_LOAD) return INSTR_TYPE_I;
        if (op == OP_STORE)  return INSTR_TYPE_S;
        if (op == OP_BRANCH) return INSTR_TYPE_B;
        if (op == OP_LUI)    return INSTR_TYPE_U;
        if (op == OP_JAL)    return INSTR_TYPE_J;
        return INSTR_TYPE_R;
    endfunction

    // Runs one instruction: wf fetch wait cycles, wd data wait cycles.
    task automatic run_instr(input logic [6:0] op, input logic z, input int wf, input int wd);
        int total;
        int data_start;
        int n_ir, n_pc, n_rw, n_rw_data, n_mreq, n_mwr, n_a11, n_sub;
        total = base_cycles(op) + wf + (is_mem(op) ? wd : 0);
        data_start = wf + 3;
        n_ir = 0; n_pc = 0; n_rw = 0; n_rw_data = 0; n_mreq = 0; n_mwr = 0; n_a11 = 0; n_sub = 0;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            opcode = op;
            zero = z;
            if (c <= wf) mem_ready = (c == wf);
            else if (is_mem(op) && c >= data_start && c <= data_start + wd) mem_ready = (c == data_start + wd);
            else mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (c == 0) check("instr_type", 32'(instr_type_enum_inst), 32'(exp_type(op)));
            if (ir_write) n_ir++;
            if (pc_write) n_pc++;
            if (reg_write) n_rw++;
            if (reg_write && result_src == 2'b01) n_rw_data++;
            if (mem_req) n_mreq++;
            if (mem_write) n_mwr++;
            if (alu_src_a == 2'b11) n_a11++;
            if (alu_op == 2'b01) n_sub++;
        end
        model_instret = model_instret + 32'd1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("refetch_req", {30'd0, mem_req, adr_src}, 32'd2);
        check("refetch_wr", 32'(mem_write), 32'd0);
        check("instret", instret, model_instret);
        check("ir_write_cnt", n_ir, 1);
        check("pc_write_cnt", n_pc, 1 + ((op == OP_JAL) ? 1 : 0) + ((op == OP_BRANCH && z) ? 1 : 0));
        check("reg_write_cnt", n_rw, exp_reg_writes(op));
        check("reg_write_data", n_rw_data, (op == OP_LOAD) ? 1 : 0);
        check("mem_req_cnt", n_mreq, wf + 1 + (is_mem(op) ? wd + 1 : 0));
        check("mem_write_cnt", n_mwr, (op == OP_STORE) ? wd + 1 : 0);
        check("srca_zero_cnt", n_a11, (op == OP_LUI) ? 1 : 0);
        check("alu_sub_cnt", n_sub, (op == OP_BRANCH) ? 1 : 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_instret = 32'd0;
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] op;
        ops[0] = OP_LOAD;  ops[1] = OP_STORE; ops[2] = OP_R;   ops[3] = OP_IMM;
        ops[4] = OP_BRANCH; ops[5] = OP_JAL;  ops[6] = OP_LUI;

        // Reset holds every enable low even with mem_ready high.
        opcode = OP_R;
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ir_write", 32'(ir_write), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_illegal", 32'(illegal_instr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("first_fetch", {29'd0, mem_req, ir_write, pc_write}, 32'd7);
        check("first_fetch_b", 32'(alu_src_b), 32'd2);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("after_fetch_state", 32'(dbg_state), 32'(ST_DECODE));
        check("decode_srcs", {28'd0, alu_src_a, alu_src_b}, 32'h5);
        do_reset();

        // Directed: lw with 3 data wait cycles, beq both ways, lui.
        run_instr(OP_LOAD, 1'b0, 0, 3);
        run_instr(OP_BRANCH, 1'b1, 0, 0);
        run_instr(OP_BRANCH, 1'b0, 0, 0);
        run_instr(OP_LUI, 1'b0, 0, 0);

        // Random stream.
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 6)];
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Counter wrap on an R-type retire.
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        model_instret = 32'hFFFF_FFFF;
        run_instr(OP_R, 1'b0, 1, 0);
        run_instr(OP_IMM, 1'b1, 0, 0);

        // Reset in the middle of a store that is still waiting.
        @(negedge clk);
        opcode = OP_STORE;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("memwrite_active", {30'd0, mem_req, mem_write}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("rst_drop_req", {30'd0, mem_req, mem_write}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_FETCH));
        check("rst_instret_mid", instret, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_instret = 32'd0;
        run_instr(OP_JAL, 1'b0, 0, 0);

        // Unsupported opcode halts the core until reset.
        @(negedge clk);
        opcode = 7'b1110011;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("illegal_decode", 32'(dbg_state), 32'(ST_DECODE));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            check("illegal_flag", 32'(illegal_instr), 32'd1);
            check("illegal_enables", {27'd0, mem_req, mem_write, ir_write, pc_write, reg_write}, 32'd0);
        end
        check("illegal_instret", instret, model_instret);
        do_reset();
        #1;
        check("illegal_cleared", 32'(illegal_instr), 32'd0);
        run_instr(OP_STORE, 1'b0, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
